axi_lite_master_if: RTL

- Core-side bus master that sits directly upstream of the MMU/interconnect.
- Converts the core's single-outstanding load/store request (enable pulse, address, data, strobe) into AXI4-Lite read or write transactions on the core_axi_* bus.
- Returns read data, a one-cycle done pulse and an error flag to the core.
- Exactly one transaction is outstanding at a time.

---
 rtl/axi_lite_pkg.sv | 30 +++
 rtl/axi_lite_master_if.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite core-side master.
// Contents:
//   state_t      - FSM state encoding; the values are visible on the debug port
//   RESP_*       - AXI response codes
//   PROT_DEFAULT - default value driven on arprot/awprot
//   resp_is_err  - maps a response code to the core-side error flag
package axi_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // Anything other than OKAY is reported to the core as an error. This
  // includes EXOKAY, because the core never issues exclusive accesses.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/axi_lite_master_if.sv
// Core-side AXI4-Lite master. Turns a single-outstanding load/store request
// into one AXI4-Lite read or write transaction.
// Ports:
//   clk, rstn                 - clock and asynchronous active-low reset
//   rd_enable, wr_enable      - request strobes, sampled only while idle
//   addr, wdata, wstrb        - request payload
//   rdata, done, err, busy    - core-side results and status
//   axi_ar*, axi_r*           - AXI read address and read data channels
//   axi_aw*, axi_w*, axi_b*   - AXI write address, write data and response channels
//   state                     - current FSM state, for debug
// Every output comes straight from a flop. During the done cycle the FSM
// stays in its response state, so an enable in that cycle is ignored.
module axi_lite_master_if
  import axi_lite_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [2:0] PROT   = PROT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rd_enable,
  input  logic                  wr_enable,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  done,
  output logic                  err,
  output logic                  busy,
  output logic [ADDR_W-1:0]     axi_araddr,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [2:0]            axi_arprot,
  input  logic [DATA_W-1:0]     axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  output logic [ADDR_W-1:0]     axi_awaddr,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [2:0]            axi_awprot,
  output logic [DATA_W-1:0]     axi_wdata,
  output logic [DATA_W/8-1:0]   axi_wstrb,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [2:0]            state
);

  state_t                state_r,   state_nxt_s;
  logic [ADDR_W-1:0]     araddr_r,  araddr_nxt_s;
  logic [ADDR_W-1:0]     awaddr_r,  awaddr_nxt_s;
  logic [DATA_W-1:0]     wdata_r,   wdata_nxt_s;
  logic [DATA_W/8-1:0]   wstrb_r,   wstrb_nxt_s;
  logic [DATA_W-1:0]     rdata_r,   rdata_nxt_s;
  logic                  arvalid_r, arvalid_nxt_s;
  logic                  rready_r,  rready_nxt_s;
  logic                  awvalid_r, awvalid_nxt_s;
  logic                  wvalid_r,  wvalid_nxt_s;
  logic                  bready_r,  bready_nxt_s;
  logic                  aw_done_r, aw_done_nxt_s;
  logic                  w_done_r,  w_done_nxt_s;
  logic                  done_r,    done_nxt_s;
  logic                  err_r,     err_nxt_s;
  logic                  busy_r,    busy_nxt_s;

  logic                  ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
  logic                  aw_cmpl_s, w_cmpl_s;

  assign ar_hs_s   = arvalid_r & axi_arready;
  assign r_hs_s    = rready_r  & axi_rvalid;
  assign aw_hs_s   = awvalid_r & axi_awready;
  assign w_hs_s    = wvalid_r  & axi_wready;
  assign b_hs_s    = bready_r  & axi_bvalid;
  // A channel counts as complete if it finished earlier or finishes this cycle.
  assign aw_cmpl_s = aw_done_r | aw_hs_s;
  assign w_cmpl_s  = w_done_r  | w_hs_s;

  // Next-state and next-output logic; every register holds unless changed below.
  always_comb begin
    state_nxt_s   = state_r;
    araddr_nxt_s  = araddr_r;
    awaddr_nxt_s  = awaddr_r;
    wdata_nxt_s   = wdata_r;
    wstrb_nxt_s   = wstrb_r;
    rdata_nxt_s   = rdata_r;
    arvalid_nxt_s = arvalid_r;
    rready_nxt_s  = rready_r;
    awvalid_nxt_s = awvalid_r;
    wvalid_nxt_s  = wvalid_r;
    bready_nxt_s  = bready_r;
    aw_done_nxt_s = aw_done_r;
    w_done_nxt_s  = w_done_r;
    done_nxt_s    = 1'b0;
    err_nxt_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // A write has priority; a simultaneous read request is dropped.
        if (wr_enable) begin
          awaddr_nxt_s  = addr;
          wdata_nxt_s   = wdata;
          wstrb_nxt_s   = wstrb;
          awvalid_nxt_s = 1'b1;
          wvalid_nxt_s  = 1'b1;
          aw_done_nxt_s = 1'b0;
          w_done_nxt_s  = 1'b0;
          state_nxt_s   = ST_WR_REQ;
        end else if (rd_enable) begin
          araddr_nxt_s  = addr;
          arvalid_nxt_s = 1'b1;
          state_nxt_s   = ST_RD_ADDR;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end

      ST_RD_ADDR: begin
        if (ar_hs_s) begin
          arvalid_nxt_s = 1'b0;
          rready_nxt_s  = 1'b1;
          state_nxt_s   = ST_RD_DATA;
        end else begin
          state_nxt_s   = ST_RD_ADDR;
        end
      end

      ST_RD_DATA: begin
        // done_r set means this is the done cycle; return to idle after it.
        if (done_r) begin
          state_nxt_s  = ST_IDLE;
        end else if (r_hs_s) begin
          rdata_nxt_s  = axi_rdata;
          rready_nxt_s = 1'b0;
          done_nxt_s   = 1'b1;
          err_nxt_s    = resp_is_err(axi_rresp);
        end else begin
          state_nxt_s  = ST_RD_DATA;
        end
      end

      ST_WR_REQ: begin
        // Each valid drops one cycle after its own handshake.
        if (aw_hs_s) begin
          awvalid_nxt_s = 1'b0;
        end else begin
          awvalid_nxt_s = awvalid_r;
        end
        if (w_hs_s) begin
          wvalid_nxt_s = 1'b0;
        end else begin
          wvalid_nxt_s = wvalid_r;
        end
        if (aw_cmpl_s && w_cmpl_s) begin
          bready_nxt_s  = 1'b1;
          aw_done_nxt_s = 1'b0;
          w_done_nxt_s  = 1'b0;
          state_nxt_s   = ST_WR_RESP;
        end else begin
          aw_done_nxt_s = aw_cmpl_s;
          w_done_nxt_s  = w_cmpl_s;
          state_nxt_s   = ST_WR_REQ;
        end
      end

      ST_WR_RESP: begin
        if (done_r) begin
          state_nxt_s  = ST_IDLE;
        end else if (b_hs_s) begin
          bready_nxt_s = 1'b0;
          done_nxt_s   = 1'b1;
          err_nxt_s    = resp_is_err(axi_bresp);
        end else begin
          state_nxt_s  = ST_WR_RESP;
        end
      end

      default: begin
        // Unreachable encodings: drop every handshake and recover to idle.
        arvalid_nxt_s = 1'b0;
        rready_nxt_s  = 1'b0;
        awvalid_nxt_s = 1'b0;
        wvalid_nxt_s  = 1'b0;
        bready_nxt_s  = 1'b0;
        aw_done_nxt_s = 1'b0;
        w_done_nxt_s  = 1'b0;
        state_nxt_s   = ST_IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and payload registers; reset clears every output immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      araddr_r  <= '0;
      awaddr_r  <= '0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
      rdata_r   <= '0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      araddr_r  <= araddr_nxt_s;
      awaddr_r  <= awaddr_nxt_s;
      wdata_r   <= wdata_nxt_s;
      wstrb_r   <= wstrb_nxt_s;
      rdata_r   <= rdata_nxt_s;
      arvalid_r <= arvalid_nxt_s;
      rready_r  <= rready_nxt_s;
      awvalid_r <= awvalid_nxt_s;
      wvalid_r  <= wvalid_nxt_s;
      bready_r  <= bready_nxt_s;
      aw_done_r <= aw_done_nxt_s;
      w_done_r  <= w_done_nxt_s;
      done_r    <= done_nxt_s;
      err_r     <= err_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  assign rdata       = rdata_r;
  assign done        = done_r;
  assign err         = err_r;
  assign busy        = busy_r;
  assign axi_araddr  = araddr_r;
  assign axi_arvalid = arvalid_r;
  assign axi_arprot  = PROT;
  assign axi_rready  = rready_r;
  assign axi_awaddr  = awaddr_r;
  assign axi_awvalid = awvalid_r;
  assign axi_awprot  = PROT;
  assign axi_wdata   = wdata_r;
  assign axi_wstrb   = wstrb_r;
  assign axi_wvalid  = wvalid_r;
  assign axi_bready  = bready_r;
  assign state       = state_r;

endmodule
